// File: rtl/decomp_page_ctrl.sv
// Page-completion controller for the Snappy decompressor core.
// Follows one page from its first token until the token FIFO, every parser
// lane and every history RAM bank have stayed empty for a programmable
// quiet window, then raises page_finish until the output stage reports
// cleanup done. A drain timeout parks the controller in an error state
// with a sticky flag, and completed pages are counted modulo 2^PAGE_CNT_W.
module decomp_page_ctrl #(
  parameter int NUM_PARSER   = 6,
  parameter int NUM_RAM      = 16,
  parameter int QUIET_CYCLES = 16,
  parameter int TIMEOUT_W    = 20,
  parameter int PAGE_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tf_empty,
  input  logic [NUM_PARSER-1:0] ps_empty,
  input  logic [NUM_RAM-1:0]    ram_empty,
  input  logic                  page_input_finish,
  input  logic                  cl_finish,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic                  err_clear,
  output logic                  page_finish,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [PAGE_CNT_W-1:0] page_count,
  output logic [2:0]            state_o
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    FINISH = 3'd3,
    WRAP   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t                state;
  state_t                state_d;
  logic                  input_done;
  logic                  input_done_d;
  logic [QW-1:0]         quiet_cnt;
  logic [QW-1:0]         quiet_cnt_d;
  logic [TIMEOUT_W-1:0]  timeout_cnt;
  logic [TIMEOUT_W-1:0]  timeout_cnt_d;
  logic                  all_empty_r;
  logic                  page_finish_d;
  logic                  timeout_err_d;
  logic [PAGE_CNT_W-1:0] page_count_d;
  logic                  quiet_hit;
  logic                  timeout_hit;

  assign busy    = (state != IDLE);
  assign state_o = state;

  // Next-state and next-register values; every register holds unless a state acts on it.
  always_comb begin
    state_d       = state;
    input_done_d  = input_done;
    quiet_cnt_d   = quiet_cnt;
    timeout_cnt_d = timeout_cnt;
    page_finish_d = page_finish;
    timeout_err_d = timeout_err;
    page_count_d  = page_count;
    quiet_hit     = (quiet_cnt == QUIET_MAX) && all_empty_r;
    timeout_hit   = (timeout_limit != '0) && (timeout_cnt == timeout_limit);

    case (state)
      IDLE: begin
        if (!tf_empty || input_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (input_done && tf_empty) begin
          state_d       = DRAIN;
          quiet_cnt_d   = '0;
          timeout_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!all_empty_r) begin
          quiet_cnt_d = '0;
        end else if (quiet_cnt != QUIET_MAX) begin
          quiet_cnt_d = quiet_cnt + QW'(1);
        end
        timeout_cnt_d = timeout_cnt + TIMEOUT_W'(1);
        if (quiet_hit) begin
          state_d       = FINISH;
          page_finish_d = 1'b1;
        end else if (timeout_hit) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end
      end
      FINISH: begin
        page_finish_d = 1'b1;
        if (cl_finish) begin
          page_finish_d = 1'b0;
          page_count_d  = page_count + PAGE_CNT_W'(1);
          state_d       = WRAP;
        end
      end
      WRAP: begin
        input_done_d  = 1'b0;
        quiet_cnt_d   = '0;
        timeout_cnt_d = '0;
        state_d       = IDLE;
      end
      ERR: begin
        page_finish_d = 1'b0;
        timeout_err_d = 1'b1;
        if (err_clear) begin
          timeout_err_d = 1'b0;
          input_done_d  = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new page's input-finish pulse beats the WRAP clear so back-to-back pages are not lost.
    if (page_input_finish && (state != ERR)) begin
      input_done_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      input_done  <= 1'b0;
      quiet_cnt   <= '0;
      timeout_cnt <= '0;
      all_empty_r <= 1'b0;
      page_finish <= 1'b0;
      timeout_err <= 1'b0;
      page_count  <= '0;
    end else begin
      state       <= state_d;
      input_done  <= input_done_d;
      quiet_cnt   <= quiet_cnt_d;
      timeout_cnt <= timeout_cnt_d;
      all_empty_r <= tf_empty & (&ps_empty) & (&ram_empty);
      page_finish <= page_finish_d;
      timeout_err <= timeout_err_d;
      page_count  <= page_count_d;
    end
  end

endmodule

// File: tb/tb_decomp_page_ctrl.sv
// Bench for decomp_page_ctrl: directed scenarios followed by randomized pages,
// every cycle compared against a page-level reference model.
module tb_decomp_page_ctrl;

  localparam int NP = 6;
  localparam int NR = 16;
  localparam int Q  = 16;
  localparam int TW = 20;
  localparam int PW = 4;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_DRAIN  = 2;
  localparam int S_FINISH = 3;
  localparam int S_WRAP   = 4;
  localparam int S_ERR    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tf_empty;
  logic [NP-1:0] ps_empty;
  logic [NR-1:0] ram_empty;
  logic          page_input_finish;
  logic          cl_finish;
  logic [TW-1:0] timeout_limit;
  logic          err_clear;
  logic          page_finish;
  logic          busy;
  logic          timeout_err;
  logic [PW-1:0] page_count;
  logic [2:0]    state_o;

  // Free-running clock.
  always #5 clk = ~clk;

  decomp_page_ctrl #(
    .NUM_PARSER  (NP),
    .NUM_RAM     (NR),
    .QUIET_CYCLES(Q),
    .TIMEOUT_W   (TW),
    .PAGE_CNT_W  (PW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tf_empty         (tf_empty),
    .ps_empty         (ps_empty),
    .ram_empty        (ram_empty),
    .page_input_finish(page_input_finish),
    .cl_finish        (cl_finish),
    .timeout_limit    (timeout_limit),
    .err_clear        (err_clear),
    .page_finish      (page_finish),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .page_count       (page_count),
    .state_o          (state_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: page phase, output levels, length of the current
  // all-empty run seen in drain, and cycles elapsed since drain began.
  int m_state   = 0;
  bit m_pf      = 1'b0;
  bit m_err     = 1'b0;
  bit m_done    = 1'b0;
  bit m_ae      = 1'b0;
  int m_count   = 0;
  int m_run     = 0;
  int m_elapsed = 0;

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ae_now;
    bit done_next;
    ae_now = tf_empty && (&ps_empty) && (&ram_empty);
    if (!rst_n) begin
      m_state = S_IDLE; m_pf = 1'b0; m_err = 1'b0; m_done = 1'b0; m_ae = 1'b0;
      m_count = 0; m_run = 0; m_elapsed = 0;
      return;
    end
    done_next = m_done;
    if (m_state == S_WRAP || (m_state == S_ERR && err_clear)) done_next = 1'b0;
    if (page_input_finish && m_state != S_ERR) done_next = 1'b1;
    case (m_state)
      S_IDLE: if (!tf_empty || m_done) m_state = S_RUN;
      S_RUN: begin
        if (m_done && tf_empty) begin
          m_state = S_DRAIN; m_run = 0; m_elapsed = 0;
        end
      end
      S_DRAIN: begin
        if (m_ae && m_run >= Q) begin
          m_state = S_FINISH; m_pf = 1'b1;
        end else if (timeout_limit != 0 && (m_elapsed % (1 << TW)) == int'(timeout_limit)) begin
          m_state = S_ERR; m_err = 1'b1;
        end
        m_run = m_ae ? m_run + 1 : 0;
        m_elapsed++;
      end
      S_FINISH: begin
        if (cl_finish) begin
          m_pf = 1'b0; m_count = (m_count + 1) % (1 << PW); m_state = S_WRAP;
        end
      end
      S_WRAP: m_state = S_IDLE;
      S_ERR: begin
        if (err_clear) begin
          m_err = 1'b0; m_state = S_IDLE;
        end
      end
      default: m_state = S_IDLE;
    endcase
    m_done = done_next;
    m_ae   = ae_now;
  endtask

  task automatic checkOutput();
    expect_val("page_finish", 32'(page_finish), 32'(m_pf));
    expect_val("busy",        32'(busy),        32'(m_state != S_IDLE));
    expect_val("timeout_err", 32'(timeout_err), 32'(m_err));
    expect_val("page_count",  32'(page_count),  32'(m_count));
    expect_val("state_o",     32'(state_o),     32'(m_state));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput();
  endtask

  function automatic logic [NP-1:0] partial_ps();
    logic [NP-1:0] v;
    v = NP'($urandom);
    v[$urandom_range(NP-1, 0)] = 1'b0;
    return v;
  endfunction

  function automatic logic [NR-1:0] partial_ram();
    logic [NR-1:0] v;
    v = NR'($urandom);
    v[$urandom_range(NR-1, 0)] = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input bit tf, input bit ps_all, input bit ram_all,
                               input bit pif, input bit clf, input bit ec);
    tf_empty          = tf;
    ps_empty          = ps_all ? {NP{1'b1}} : partial_ps();
    ram_empty         = ram_all ? {NR{1'b1}} : partial_ram();
    page_input_finish = pif;
    cl_finish         = clf;
    err_clear         = ec;
    tick();
    page_input_finish = 1'b0;
    cl_finish         = 1'b0;
    err_clear         = 1'b0;
  endtask

  // First all-empty sample happens on the first edge here; counts edges until page_finish.
  task automatic measure_finish(input string tag);
    int n;
    applyStimulus(1, 1, 1, 0, 0, 0);
    n = 0;
    while (page_finish !== 1'b1 && n < 400) begin
      applyStimulus(1, 1, 1, 0, 0, 0);
      n++;
    end
    expect_val(tag, 32'(n), 32'(Q + 1));
  endtask

  task automatic stuck_tick();
    tf_empty     = 1'b1;
    ps_empty     = {NP{1'b1}};
    ps_empty[2]  = 1'b0;
    ram_empty    = {NR{1'b1}};
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; tf_empty = 1'b1; ps_empty = '1; ram_empty = '1;
    page_input_finish = 1'b0; cl_finish = 1'b0; err_clear = 1'b0; timeout_limit = '0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 0, 0, 0);
    expect_val("reset_idle", 32'(state_o), 32'(S_IDLE));

    // Nominal page
    repeat (10) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    measure_finish("nominal_latency");
    repeat (3) applyStimulus(bit'($urandom_range(1)), 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 0);
    expect_val("nominal_pf_drop", 32'(page_finish), 32'd0);
    expect_val("nominal_count", 32'(page_count), 32'd1);
    applyStimulus(1, 1, 1, 0, 0, 0);
    expect_val("nominal_idle", 32'(state_o), 32'(S_IDLE));

    // Quiet window restart on a single RAM-bank blip
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    repeat (10) applyStimulus(1, 1, 1, 0, 0, 0);
    tf_empty = 1'b1; ps_empty = '1; ram_empty = '1; ram_empty[5] = 1'b0;
    tick();
    measure_finish("restart_latency");

    // Back-to-back: next page's input-finish lands in WRAP
    applyStimulus(1, 1, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    expect_val("b2b_run", 32'(state_o), 32'(S_RUN));
    measure_finish("b2b_latency");
    applyStimulus(1, 1, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    expect_val("b2b_count", 32'(page_count), 32'd3);

    // Drain timeout with a stuck parser lane
    timeout_limit = TW'(100);
    applyStimulus(0, 0, 0, 1, 0, 0);
    stuck_tick();
    n = 0;
    while (timeout_err !== 1'b1 && n < 300) begin
      stuck_tick();
      n++;
    end
    expect_val("timeout_edges", 32'(n), 32'd101);
    expect_val("timeout_state", 32'(state_o), 32'(S_ERR));
    applyStimulus(1, 1, 1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 1);
    expect_val("errclr_state", 32'(state_o), 32'(S_IDLE));
    expect_val("errclr_count", 32'(page_count), 32'd3);
    applyStimulus(1, 1, 1, 0, 0, 0);
    expect_val("errclr_stays_idle", 32'(state_o), 32'(S_IDLE));

    // Timeout disabled: a long stall never errors
    timeout_limit = '0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    repeat (3000) stuck_tick();
    expect_val("no_timeout", 32'(timeout_err), 32'd0);
    measure_finish("long_drain_latency");
    applyStimulus(1, 1, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);

    // Reset in the middle of a drain
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    repeat (8) applyStimulus(1, 1, 1, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_val("midreset_count", 32'(page_count), 32'd0);
    expect_val("midreset_pf", 32'(page_finish), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    measure_finish("post_reset_latency");
    applyStimulus(1, 1, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    expect_val("post_reset_count", 32'(page_count), 32'd1);

    // Randomized pages, including counter wrap and timeouts
    for (int p = 0; p < 48; p++) begin
      int len;
      int guard;
      bit blip;
      timeout_limit = ($urandom_range(2) == 0) ? TW'($urandom_range(80, 20)) : '0;
      len = $urandom_range(6, 0);
      for (int i = 0; i < len; i++)
        applyStimulus(0, 0, 0, 0, bit'($urandom_range(1)), bit'($urandom_range(1)));
      applyStimulus(bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)), 1, 0, 0);
      guard = 0;
      while (m_state != S_FINISH && m_state != S_ERR && guard < 1000) begin
        blip = ($urandom_range(23) == 0);
        applyStimulus(1, !(blip && $urandom_range(1) == 0), !blip, 0, bit'($urandom_range(1)), 0);
        guard++;
      end
      expect_val("random_page_bound", 32'(guard < 1000), 32'd1);
      if (m_state == S_FINISH) begin
        repeat ($urandom_range(3)) applyStimulus(bit'($urandom_range(1)), 0, 0, 0, 0, 0);
        applyStimulus(bit'($urandom_range(1)), 0, 0, 0, 1, 0);
        if ($urandom_range(1) == 1) applyStimulus(1, 1, 1, 1, 0, 0);
        else applyStimulus(1, 1, 1, 0, 0, 0);
      end else begin
        repeat ($urandom_range(3)) applyStimulus(1, 1, 1, 0, 1, 0);
        applyStimulus(1, 1, 1, 0, 0, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decomp_page_ctrl.md
Name: decomp_page_ctrl

Overview:
Parametrised page-completion controller for the Snappy decompressor core. Tracks one page from first token through drain of the token FIFO, all parsers and all history RAM banks. Asserts page_finish once the datapath has been quiet for a programmable window, and holds it until the output stage reports cleanup done. Adds a drain timeout with a sticky error flag, a completed-page counter and a status view. Supports back-to-back pages.

Parameters:
NUM_PARSER, 6, number of parser lanes (ps_empty width)
NUM_RAM, 16, number of history RAM banks (ram_empty width)
QUIET_CYCLES, 16, consecutive all-empty cycles required before page_finish (1..255)
TIMEOUT_W, 20, width of drain timeout counter and timeout_limit
PAGE_CNT_W, 16, width of completed-page counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
tf_empty  in  1  token FIFO empty
ps_empty  in  NUM_PARSER  per-parser empty
ram_empty  in  NUM_RAM  per-RAM-bank empty
page_input_finish  in  1  pulse: last input beat of page pre-parsed
cl_finish  in  1  pulse: output/cleanup of page complete
timeout_limit  in  TIMEOUT_W  max drain cycles; 0 disables timeout
err_clear  in  1  pulse: clear timeout error, return to IDLE
page_finish  out  1  level: page fully decompressed into BRAMs
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky drain-timeout flag
page_count  out  PAGE_CNT_W  pages completed, wraps modulo 2^PAGE_CNT_W
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. page_finish=0, busy=0, timeout_err=0, page_count=0. Internal input_done, quiet_cnt, timeout_cnt and all_empty_r are cleared. A reset mid-page abandons the page with no count increment.
- all_empty_r is registered each cycle: tf_empty & (&ps_empty) & (&ram_empty).
- input_done is a sticky flag. It is set by page_input_finish in any state except ERR, and cleared in WRAP and on reset. A pulse arriving in IDLE is retained.
- States, encoded 0..4: IDLE, RUN, DRAIN, FINISH, WRAP; ERR=5.
- IDLE: leave for RUN when ~tf_empty or input_done (the latter covers an empty page).
- RUN: go to DRAIN when input_done & tf_empty. On entry to DRAIN, quiet_cnt=0 and timeout_cnt=0.
- DRAIN:
  - quiet_cnt increments when all_empty_r=1 and resets to 0 when all_empty_r=0. It saturates at QUIET_CYCLES.
  - timeout_cnt increments every cycle.
  - When quiet_cnt==QUIET_CYCLES and all_empty_r=1: go to FINISH, page_finish=1 from the same edge.
  - Latency: with inputs first sampled all-empty at edge e0 and held, page_finish is high after edge e0+QUIET_CYCLES+1.
  - When timeout_limit!=0 and timeout_cnt==timeout_limit: go to ERR, timeout_err=1.
  - If finish and timeout are both true on the same edge, finish wins.
  - cl_finish is ignored in DRAIN.
- FINISH: page_finish is held at 1 regardless of empties. On cl_finish: page_finish=0, page_count+=1, go to WRAP.
- WRAP: one cycle. input_done and counters are cleared, then go to IDLE. A page_input_finish arriving in WRAP is retained: the set takes priority over the clear.
- ERR: page_finish=0 and timeout_err=1. Only err_clear (or reset) leaves ERR; it clears timeout_err, clears input_done and goes to IDLE. page_count is unchanged.
- err_clear outside ERR has no effect. cl_finish outside FINISH has no effect.
- busy = (state != IDLE).
- All outputs are registered except busy and state_o, which are decoded from the state register.

Test Plan:
1. Nominal page: tf_empty=0 for 10 cycles, page_input_finish pulse, then all empties=1, QUIET_CYCLES=16 -> page_finish rises exactly 17 edges after first all-empty sample. cl_finish -> page_finish=0 next edge, page_count=1, IDLE two edges later.
2. Quiet-window restart: in DRAIN, ram_empty[5]=0 for one cycle at quiet_cnt=10 -> quiet_cnt resets. page_finish occurs 17 edges after the blip clears, never earlier.
3. Timeout: timeout_limit=100, ps_empty[2] stuck 0 -> timeout_err=1 and state_o=5 after 100 DRAIN cycles, page_finish stays 0. err_clear -> timeout_err=0, IDLE, page_count unchanged. Repeat with timeout_limit=0 -> no error after 10^5 cycles.
4. Back-to-back: second page's page_input_finish pulse lands in WRAP -> retained, controller goes IDLE->RUN->DRAIN without losing it. page_count=2 after second cl_finish.
5. Reset mid-DRAIN at quiet_cnt=8 -> all outputs 0, page_count=0. Next page completes normally.
6. Parameter sweep NUM_PARSER=8, NUM_RAM=32, QUIET_CYCLES=1 -> single ram_empty bit low blocks finish. page_finish latency = 2 edges. page_count wraps 0xFFFF->0 with PAGE_CNT_W=16 after preload via 65536 short pages (or PAGE_CNT_W=4, 16 pages).
